// File: rtl/aes_decrypt_iterative.sv
// Iterative AES inverse cipher (128/192/256-bit keys), one round per clock.
// Round keys are expanded once per key load, one word per cycle, into a local store.
module aes_decrypt_iterative #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         KEY_VALID,
    output logic         KEY_READY,
    input  logic [255:0] KEY,
    output logic         KEY_LOADED,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA
);
    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned KW = $clog2(NW);
    localparam int unsigned RW = $clog2(NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_decrypt_iterative: KEY_BITS must be 128, 192 or 256");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] res;
        p   = a;
        res = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p   = gf_mul(p, p);
            res = gf_mul(res, p);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // InvShiftRows, InvSubBytes, AddRoundKey, then optional InvMixColumns.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic mix);
        logic [7:0]   b [16];
        logic [7:0]   m [4];
        logic [7:0]   acc;
        logic [127:0] o;
        m[0] = 8'h0e;
        m[1] = 8'h0b;
        m[2] = 8'h0d;
        m[3] = 8'h09;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[4*c+r] = inv_sbox(s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8])
                           ^ rk[127 - 8*(4*c + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = b[4*c+r];
                if (mix) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(b[4*c+j], m[(j - r + 4) % 4]);
                end
                o[127 - 8*(4*c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    typedef enum logic [2:0] {StIdle, StKexp, StReady, StRound, StDone} state_e;

    state_e         state_q;
    logic           key_loaded_q;
    logic [127:0]   data_q;
    logic [127:0]   out_q;
    logic [KW-1:0]  kidx_q;
    logic [2:0]     kmod_q;
    logic [7:0]     rcon_q;
    logic [RW-1:0]  round_q;
    logic [31:0]    win_q [NK];
    logic [31:0]    rk_q [NR+1][4];

    logic [31:0]    kx_temp;
    logic [31:0]    kx_word;
    logic [127:0]   rk_cur;
    logic [127:0]   rk_last;
    logic [127:0]   round_out;
    logic           unused_key;

    // win_q is a sliding window of the last NK words: win_q[0] = w[i-NK], win_q[NK-1] = w[i-1].
    // During the first NK cycles it rotates the captured key through unchanged.
    always_comb begin
        kx_temp = win_q[NK-1];
        if (kmod_q == 3'd0) begin
            kx_temp = sub_word({kx_temp[23:0], kx_temp[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && kmod_q == 3'd4) begin
            kx_temp = sub_word(kx_temp);
        end
        kx_word = (kidx_q < KW'(NK)) ? win_q[0] : (win_q[0] ^ kx_temp);
    end

    assign rk_cur     = {rk_q[round_q][0], rk_q[round_q][1], rk_q[round_q][2], rk_q[round_q][3]};
    assign rk_last    = {rk_q[NR][0], rk_q[NR][1], rk_q[NR][2], rk_q[NR][3]};
    assign round_out  = inv_round(data_q, rk_cur, round_q != '0);
    assign unused_key = ^KEY;

    // KEY_READY is masked while RST is held so every output reads 0 during reset.
    assign KEY_READY  = !RST && (state_q == StIdle || state_q == StReady);
    assign IN_READY   = (state_q == StReady) && !KEY_VALID;
    assign OUT_VALID  = (state_q == StDone);
    assign OUT_DATA   = out_q;
    assign KEY_LOADED = key_loaded_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            key_loaded_q <= 1'b0;
            data_q       <= '0;
            out_q        <= '0;
            kidx_q       <= '0;
            kmod_q       <= '0;
            rcon_q       <= 8'h01;
            round_q      <= '0;
            for (int j = 0; j < NK; j++) win_q[j] <= '0;
        end else begin
            case (state_q)
                StIdle, StReady: begin
                    if (KEY_VALID) begin
                        state_q      <= StKexp;
                        key_loaded_q <= 1'b0;
                        kidx_q       <= '0;
                        kmod_q       <= '0;
                        rcon_q       <= 8'h01;
                        for (int j = 0; j < NK; j++) win_q[j] <= KEY[255 - 32*j -: 32];
                    end else if (state_q == StReady && IN_VALID) begin
                        data_q  <= IN_DATA ^ rk_last;
                        round_q <= RW'(NR - 1);
                        state_q <= StRound;
                    end
                end
                StKexp: begin
                    for (int j = 0; j < NK - 1; j++) win_q[j] <= win_q[j+1];
                    win_q[NK-1] <= kx_word;
                    kidx_q      <= kidx_q + 1'b1;
                    kmod_q      <= (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
                    if (kmod_q == 3'd0 && kidx_q >= KW'(NK)) rcon_q <= xtime(rcon_q);
                    if (kidx_q == KW'(NW - 1)) begin
                        state_q      <= StReady;
                        key_loaded_q <= 1'b1;
                    end
                end
                StRound: begin
                    data_q <= round_out;
                    if (round_q == '0) begin
                        out_q   <= round_out;
                        state_q <= StDone;
                    end else begin
                        round_q <= round_q - 1'b1;
                    end
                end
                StDone: begin
                    if (OUT_READY) state_q <= StReady;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Round-key store: rk[n] = w[4n..4n+3].
    always_ff @(posedge CLK) begin
        if (state_q == StKexp) rk_q[kidx_q[KW-1:2]][kidx_q[1:0]] <= kx_word;
    end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for aes_decrypt_iterative: one instance per key size, known-answer vectors plus
// backpressure, key/data collision and mid-round reset sequences.
module tb_aes_decrypt_iterative;

    typedef struct {
        int           inst;
        logic [255:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           nr;
    } vec_t;

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT_SP   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT_APPB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_SP   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] CT_APPB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K128_F  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256_F  =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256_F = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT256_S = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic         clk;
    logic         rst;
    logic         key_valid  [3];
    logic         key_ready  [3];
    logic [255:0] key        [3];
    logic         key_loaded [3];
    logic         in_valid   [3];
    logic         in_ready   [3];
    logic [127:0] in_data    [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic [127:0] out_data   [3];

    int   checks;
    int   failures;
    vec_t vecs [7];

    aes_decrypt_iterative #(.KEY_BITS(128)) u_dut128 (
        .CLK(clk), .RST(rst), .KEY_VALID(key_valid[0]), .KEY_READY(key_ready[0]), .KEY(key[0]),
        .KEY_LOADED(key_loaded[0]), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .IN_DATA(in_data[0]), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]),
        .OUT_DATA(out_data[0])
    );
    aes_decrypt_iterative #(.KEY_BITS(192)) u_dut192 (
        .CLK(clk), .RST(rst), .KEY_VALID(key_valid[1]), .KEY_READY(key_ready[1]), .KEY(key[1]),
        .KEY_LOADED(key_loaded[1]), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .IN_DATA(in_data[1]), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]),
        .OUT_DATA(out_data[1])
    );
    aes_decrypt_iterative #(.KEY_BITS(256)) u_dut256 (
        .CLK(clk), .RST(rst), .KEY_VALID(key_valid[2]), .KEY_READY(key_ready[2]), .KEY(key[2]),
        .KEY_LOADED(key_loaded[2]), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
        .IN_DATA(in_data[2]), .OUT_VALID(out_valid[2]), .OUT_READY(out_ready[2]),
        .OUT_DATA(out_data[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 128'(act), 128'(exp));
    endtask

    // Key transfer, then count edges until KEY_LOADED; KEY_VALID is waved mid-expansion.
    task automatic load_key(input int d, input logic [255:0] k, input int nr);
        int n;
        @(negedge clk);
        key[d]       = k;
        key_valid[d] = 1'b1;
        n = 0;
        while (key_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit($sformatf("i%0d key_ready before load", d), key_ready[d], 1'b1);
        @(negedge clk);
        key_valid[d] = 1'b0;
        check_bit($sformatf("i%0d key_loaded cleared", d), key_loaded[d], 1'b0);
        n = 0;
        while (key_loaded[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 3) begin
                key[d]       = ~k;
                key_valid[d] = 1'b1;
            end
            if (n == 6) begin
                check_bit($sformatf("i%0d key_ready in kexp", d), key_ready[d], 1'b0);
                key[d]       = k;
                key_valid[d] = 1'b0;
            end
        end
        check($sformatf("i%0d kexp cycles", d), 128'(n), 128'(4 * (nr + 1)));
    endtask

    // Count edges after the accept edge until OUT_VALID is seen.
    task automatic wait_out(input int d, output int n);
        n = 0;
        while (out_valid[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic decrypt(input int d, input logic [127:0] ct, input logic [127:0] pt,
                           input int nr);
        int n;
        @(negedge clk);
        in_data[d]  = ct;
        in_valid[d] = 1'b1;
        n = 0;
        while (in_ready[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_bit($sformatf("i%0d in_ready", d), in_ready[d], 1'b1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d]  = ~ct;
        check_bit($sformatf("i%0d in_ready in round", d), in_ready[d], 1'b0);
        check_bit($sformatf("i%0d key_ready in round", d), key_ready[d], 1'b0);
        wait_out(d, n);
        check($sformatf("i%0d latency edges", d), 128'(n), 128'(nr));
        check($sformatf("i%0d plaintext", d), out_data[d], pt);
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        check_bit($sformatf("i%0d out_valid after take", d), out_valid[d], 1'b0);
        check_bit($sformatf("i%0d in_ready after take", d), in_ready[d], 1'b1);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        vecs[0] = '{0, {K128_F, 128'h0}, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_FIPS, 10};
        vecs[1] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, CT_APPB, PT_APPB, 10};
        vecs[2] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, CT_SP, PT_SP, 10};
        vecs[3] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_FIPS, 12};
        vecs[4] = '{1, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0},
                    128'hbd334f1d6e45f25ff712a214571fa5cc, PT_SP, 12};
        vecs[5] = '{2, K256_F, CT256_F, PT_FIPS, 14};
        vecs[6] = '{2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    CT256_S, PT_SP, 14};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            key_valid[d] = 1'b0;
            key[d]       = '0;
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            out_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_bit($sformatf("i%0d reset key_ready", d), key_ready[d], 1'b0);
            check_bit($sformatf("i%0d reset key_loaded", d), key_loaded[d], 1'b0);
            check_bit($sformatf("i%0d reset in_ready", d), in_ready[d], 1'b0);
            check_bit($sformatf("i%0d reset out_valid", d), out_valid[d], 1'b0);
            check($sformatf("i%0d reset out_data", d), out_data[d], 128'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_bit($sformatf("i%0d idle key_ready", d), key_ready[d], 1'b1);
            check_bit($sformatf("i%0d idle in_ready", d), in_ready[d], 1'b0);
        end

        for (int v = 0; v < 7; v++) begin
            load_key(vecs[v].inst, vecs[v].key, vecs[v].nr);
            decrypt(vecs[v].inst, vecs[v].ct, vecs[v].pt, vecs[v].nr);
        end

        // Backpressure: hold DONE for 20 cycles with a second block waiting upstream.
        @(negedge clk);
        in_data[0]  = CT_SP;
        in_valid[0] = 1'b1;
        n = 0;
        while (in_ready[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_data[0] = CT_APPB;
        wait_out(0, n);
        check("bp latency edges", 128'(n), 128'(10));
        for (int c = 0; c < 20; c++) begin
            check_bit("bp out_valid held", out_valid[0], 1'b1);
            check("bp out_data held", out_data[0], PT_SP);
            check_bit("bp in_ready held low", in_ready[0], 1'b0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check_bit("bp out_valid after release", out_valid[0], 1'b0);
        check_bit("bp in_ready after release", in_ready[0], 1'b1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check_bit("bp second block accepted", in_ready[0], 1'b0);
        wait_out(0, n);
        check("bp second latency", 128'(n), 128'(10));
        check("bp second plaintext", out_data[0], PT_APPB);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        // Key and block offered together in READY: key wins, block waits for the new key.
        @(negedge clk);
        key[0]       = {K128_F, 128'h0};
        key_valid[0] = 1'b1;
        in_data[0]   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        in_valid[0]  = 1'b1;
        #1;
        check_bit("coll in_ready low", in_ready[0], 1'b0);
        check_bit("coll key_ready high", key_ready[0], 1'b1);
        @(negedge clk);
        key_valid[0] = 1'b0;
        check_bit("coll key_loaded cleared", key_loaded[0], 1'b0);
        n = 0;
        while (key_loaded[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 5) check_bit("coll in_ready in kexp", in_ready[0], 1'b0);
        end
        check("coll kexp cycles", 128'(n), 128'(44));
        check_bit("coll in_ready after kexp", in_ready[0], 1'b1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        wait_out(0, n);
        check("coll latency edges", 128'(n), 128'(10));
        check("coll plaintext new key", out_data[0], PT_FIPS);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        // Reset in the middle of a 256-bit decryption.
        @(negedge clk);
        in_data[2]  = CT256_S;
        in_valid[2] = 1'b1;
        n = 0;
        while (in_ready[2] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_bit("rst out_valid", out_valid[2], 1'b0);
        check_bit("rst key_loaded", key_loaded[2], 1'b0);
        check_bit("rst in_ready", in_ready[2], 1'b0);
        check_bit("rst key_ready", key_ready[2], 1'b0);
        check("rst out_data", out_data[2], 128'h0);
        check("rst out_data i0", out_data[0], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        in_data[2]  = CT256_F;
        in_valid[2] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check_bit("post-rst in_ready", in_ready[2], 1'b0);
            check_bit("post-rst out_valid", out_valid[2], 1'b0);
        end
        check_bit("post-rst key_ready", key_ready[2], 1'b1);
        in_valid[2] = 1'b0;
        load_key(2, K256_F, 14);
        decrypt(2, CT256_F, PT_FIPS, 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
